pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - in-order pipeline control: valid tracking, hazard stalls, memory wait, flush, forwarding
// Stage 0 = IF, 1 = ID, 2 = EX/M, STAGES-1 = WB.

module pipe_ctrl #(
   parameter int STAGES  = 4,
   parameter int RA_W    = 5,
   parameter int MEM_LAT = 2,
   parameter int CNT_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_valid,
   input  logic [RA_W-1:0]   id_rs1,
   input  logic [RA_W-1:0]   id_rs2,
   input  logic              id_use1,
   input  logic              id_use2,
   input  logic [RA_W-1:0]   ex_rd,
   input  logic              ex_regwrite,
   input  logic              ex_memread,
   input  logic              ex_memop,
   input  logic [RA_W-1:0]   wb_rd,
   input  logic              wb_regwrite,
   input  logic              redirect,
   output logic              pc_en,
   output logic [STAGES-1:0] stage_en,
   output logic [STAGES-1:0] stage_valid,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt,
   output logic [CNT_W-1:0]  retire_cnt
);

   localparam int WB = STAGES - 1;

   typedef enum logic [1:0] {RUN, MWAIT, FLUSH} state_t;

   state_t            state;
   logic [3:0]        wait_cnt;
   logic [STAGES-1:0] valid;
   logic [STAGES-1:0] valid_nxt;
   logic              redirect_ok;
   logic              load_use;
   logic              mem_start;

   assign stage_valid = valid;
   assign redirect_ok = redirect & valid[WB];
   assign mem_start   = (state == RUN) & valid[2] & ex_memop & (MEM_LAT > 1);

   always_comb begin
      load_use = valid[1] & valid[2] & ex_memread & (ex_rd != '0) &
                 ((id_use1 & (id_rs1 == ex_rd)) | (id_use2 & (id_rs2 == ex_rd)));
   end

   // A taken redirect overrides any stall so the correct-path fetch starts at once.
   always_comb begin
      pc_en    = 1'b1;
      stage_en = '1;
      if (!redirect_ok) begin
         if (state == MWAIT) begin
            pc_en         = 1'b0;
            stage_en[2:0] = 3'b000;
         end else if (state == RUN && load_use) begin
            pc_en         = 1'b0;
            stage_en[1:0] = 2'b00;
         end
      end
   end

   always_comb begin
      valid_nxt = valid;
      if (redirect_ok) begin
         valid_nxt = '0;
      end else begin
         if (stage_en[0]) valid_nxt[0] = if_valid;
         for (int i = 1; i < STAGES; i++) begin
            if (stage_en[i]) valid_nxt[i] = valid[i-1];
         end
         if (state == MWAIT)
            valid_nxt[3] = 1'b0;
         else if (!pc_en)
            valid_nxt[2] = 1'b0;
      end
   end

   // EX result takes precedence over WB; loads in EX cannot forward yet.
   always_comb begin
      fwd_a = 2'b00;
      if (valid[2] & ex_regwrite & !ex_memread & (ex_rd != '0) & (ex_rd == id_rs1) & id_use1)
         fwd_a = 2'b01;
      else if (valid[WB] & wb_regwrite & (wb_rd != '0) & (wb_rd == id_rs1) & id_use1)
         fwd_a = 2'b10;
   end

   always_comb begin
      fwd_b = 2'b00;
      if (valid[2] & ex_regwrite & !ex_memread & (ex_rd != '0) & (ex_rd == id_rs2) & id_use2)
         fwd_b = 2'b01;
      else if (valid[WB] & wb_regwrite & (wb_rd != '0) & (wb_rd == id_rs2) & id_use2)
         fwd_b = 2'b10;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RUN;
         wait_cnt   <= 4'd0;
         valid      <= '0;
         stall_cnt  <= '0;
         flush_cnt  <= '0;
         retire_cnt <= '0;
      end else begin
         valid <= valid_nxt;

         if (!pc_en && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (redirect_ok && flush_cnt != '1)
            flush_cnt <= flush_cnt + CNT_W'(1);
         if (valid[WB] && retire_cnt != '1)
            retire_cnt <= retire_cnt + CNT_W'(1);

         if (redirect_ok) begin
            state    <= FLUSH;
            wait_cnt <= 4'd0;
         end else begin
            case (state)
               RUN: begin
                  if (mem_start) begin
                     state    <= MWAIT;
                     wait_cnt <= 4'(MEM_LAT - 1);
                  end
               end
               MWAIT: begin
                  if (wait_cnt <= 4'd1) begin
                     state    <= RUN;
                     wait_cnt <= 4'd0;
                  end else begin
                     wait_cnt <= wait_cnt - 4'd1;
                  end
               end
               FLUSH:   state <= RUN;
               default: state <= RUN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl

module tb_pipe_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       if_valid;
   logic [4:0] id_rs1, id_rs2, ex_rd, wb_rd;
   logic       id_use1, id_use2;
   logic       ex_regwrite, ex_memread, ex_memop;
   logic       wb_regwrite, redirect;
   logic       pc_en;
   logic [3:0] stage_en, stage_valid;
   logic [1:0] fwd_a, fwd_b;
   logic [3:0] stall_cnt, flush_cnt, retire_cnt;

   int total = 0;
   int bad   = 0;

   pipe_ctrl #(.STAGES(4), .RA_W(5), .MEM_LAT(3), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .if_valid(if_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
      .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memop(ex_memop),
      .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .redirect(redirect),
      .pc_en(pc_en), .stage_en(stage_en), .stage_valid(stage_valid),
      .fwd_a(fwd_a), .fwd_b(fwd_b),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_in();
      if_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use1 = 0; id_use2 = 0;
      ex_rd = 0; ex_regwrite = 0; ex_memread = 0; ex_memop = 0;
      wb_rd = 0; wb_regwrite = 0; redirect = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clr_in();
      cyc();
      rst_n = 1'b1;
   endtask

   task automatic fill();
      if_valid = 1;
      repeat (4) cyc();
   endtask

   initial begin
      rst_n = 1'b0;
      clr_in();
      @(negedge clk);
      #1;
      chk("rst_pc_en", pc_en, 1);
      chk("rst_stage_en", stage_en, 4'hf);
      chk("rst_valid", stage_valid, 0);
      chk("rst_fwd", {fwd_a, fwd_b}, 0);
      chk("rst_cnts", {stall_cnt, flush_cnt, retire_cnt}, 0);
      rst_n = 1'b1;

      // fill and load-use
      fill();
      chk("fill_valid", stage_valid, 4'b1111);
      chk("fill_retire", retire_cnt, 0);
      ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use1 = 0;
      #1 chk("lu_unused_pc_en", pc_en, 1);
      id_use1 = 1;
      #1 chk("lu_pc_en", pc_en, 0);
      chk("lu_stage_en", stage_en, 4'b1100);
      cyc();
      ex_memread = 0;
      #1 chk("lu_valid", stage_valid, 4'b1011);
      chk("lu_stall_cnt", stall_cnt, 1);
      chk("lu_retire", retire_cnt, 1);
      chk("lu_pc_en_after", pc_en, 1);
      ex_memread = 1; ex_rd = 0; id_rs1 = 0;
      #1 chk("lu_rd0_pc_en", pc_en, 1);
      ex_memread = 0;
      cyc(); cyc();
      chk("refill_valid", stage_valid, 4'b1111);

      // forwarding
      ex_rd = 3; ex_regwrite = 1; wb_rd = 3; wb_regwrite = 1; id_rs1 = 3; id_use1 = 1;
      #1 chk("fwd_a_ex", fwd_a, 2'b01);
      ex_regwrite = 0;
      #1 chk("fwd_a_wb", fwd_a, 2'b10);
      ex_regwrite = 1; ex_rd = 0; wb_rd = 0; id_rs1 = 0;
      #1 chk("fwd_a_rd0", fwd_a, 2'b00);
      ex_rd = 7; id_rs2 = 7; id_use2 = 1;
      #1 chk("fwd_b_ex", fwd_b, 2'b01);
      id_use2 = 0;
      #1 chk("fwd_b_unused", fwd_b, 2'b00);
      clr_in();

      // memory wait, MEM_LAT=3
      do_reset();
      fill();
      ex_memop = 1;
      #1 chk("mw_detect_en", stage_en, 4'hf);
      cyc();
      ex_memop = 0;
      #1 chk("mw1_pc_en", pc_en, 0);
      chk("mw1_stage_en", stage_en, 4'b1000);
      cyc();
      chk("mw2_stage_en", stage_en, 4'b1000);
      chk("mw2_valid", stage_valid, 4'b0111);
      cyc();
      chk("mw_done_pc_en", pc_en, 1);
      chk("mw_done_stage_en", stage_en, 4'hf);
      chk("mw_stall_cnt", stall_cnt, 2);
      chk("mw_done_valid", stage_valid, 4'b0111);

      // redirect during wait
      do_reset();
      fill();
      ex_memop = 1;
      cyc();
      ex_memop = 0; if_valid = 0; redirect = 1;
      #1 chk("rd_mw_pc_en", pc_en, 1);
      chk("rd_mw_stage_en", stage_en, 4'hf);
      cyc();
      redirect = 0;
      #1 chk("rd_flush_valid", stage_valid, 4'b0000);
      chk("rd_flush_cnt", flush_cnt, 1);
      chk("rd_flush_en", {pc_en, stage_en}, 5'h1f);
      cyc();
      chk("rd_run_en", {pc_en, stage_en}, 5'h1f);
      chk("rd_stall_cnt", stall_cnt, 0);
      redirect = 1;
      cyc();
      redirect = 0;
      chk("rd_ignored", flush_cnt, 1);

      // reset mid-wait
      do_reset();
      fill();
      ex_memop = 1;
      cyc();
      ex_memop = 0;
      chk("rmw_pc_en_before", pc_en, 0);
      rst_n = 1'b0;
      #1 chk("rmw_async_en", {pc_en, stage_en}, 5'h1f);
      chk("rmw_async_valid", stage_valid, 0);
      cyc();
      rst_n = 1'b1; if_valid = 0;
      cyc();
      chk("rmw_after_en", {pc_en, stage_en}, 5'h1f);
      chk("rmw_stall_cnt", stall_cnt, 0);

      // retire counter saturation
      do_reset();
      if_valid = 1;
      repeat (18) cyc();
      chk("sat_retire14", retire_cnt, 14);
      repeat (6) cyc();
      chk("sat_retire15", retire_cnt, 15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout obs=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
